// File: rtl/bp_me_stream_pump_in.sv
// bp_me_stream_pump_in: turns an incoming stream message into per-beat FSM beats with a held header, wrapped address and beat count.
// Header layout: {msg_type[3:0], size[2:0], addr[paddr_width_p-1:0]}, where a message carries 1<<size bytes.
module bp_me_stream_pump_in #(
  parameter int paddr_width_p = 40,
  parameter int stream_data_width_p = 64,
  parameter int block_width_p = 512,
  parameter logic [15:0] mem_stream_mask_p = '0,
  parameter logic [15:0] fsm_stream_mask_p = mem_stream_mask_p,
  localparam int header_width_lp = paddr_width_p + 7,
  localparam int stream_words_lp = block_width_p / stream_data_width_p,
  localparam int data_len_width_lp = stream_words_lp > 1 ? $clog2(stream_words_lp) : 1,
  localparam int stream_offset_width_lp = stream_data_width_p > 8 ? $clog2(stream_data_width_p / 8) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [header_width_lp-1:0]     mem_header_i,
  input  logic [stream_data_width_p-1:0] mem_data_i,
  input  logic                           mem_v_i,
  input  logic                           mem_last_i,
  output logic                           mem_ready_and_o,
  output logic [header_width_lp-1:0]     fsm_base_header_o,
  output logic [paddr_width_p-1:0]       fsm_addr_o,
  output logic [stream_data_width_p-1:0] fsm_data_o,
  output logic                           fsm_v_o,
  input  logic                           fsm_ready_and_i,
  output logic [data_len_width_lp-1:0]   fsm_cnt_o,
  output logic                           fsm_new_o,
  output logic                           fsm_last_o,
  output logic                           stream_done_o
);
  typedef logic [data_len_width_lp-1:0] cnt_t;
  localparam bit single_lp = stream_words_lp == 1;
  logic streaming_q, streaming_d;
  cnt_t cnt_q, cnt_d;
  logic [header_width_lp-1:0] header_q, header_d;
  logic [paddr_width_p-1:0] addr;
  logic [2:0] size;
  logic [3:0] msg_type;
  cnt_t num_stream, first_cnt, last_cnt, cnt;
  logic fsm_stream, mem_stream, mem_only, fsm_only, advance, mem_last_beat;
  always_comb begin
    fsm_base_header_o = streaming_q ? header_q : mem_header_i;
    addr = fsm_base_header_o[paddr_width_p-1:0];
    size = fsm_base_header_o[paddr_width_p+:3];
    msg_type = fsm_base_header_o[paddr_width_p+3+:4];
    num_stream = (single_lp || 32'(size) <= 32'(stream_offset_width_lp)) ? '0
               : cnt_t'((32'd1 << (32'(size) - 32'(stream_offset_width_lp))) - 32'd1);
    first_cnt = addr[stream_offset_width_lp+:data_len_width_lp];
    last_cnt = first_cnt + num_stream;
    fsm_stream = fsm_stream_mask_p[msg_type] && first_cnt != last_cnt;
    mem_stream = mem_stream_mask_p[msg_type] && first_cnt != last_cnt;
    mem_only = mem_stream && !fsm_stream;
    fsm_only = fsm_stream && !mem_stream;
    cnt = streaming_q ? cnt_q : first_cnt;
    fsm_cnt_o = cnt;
    fsm_new_o = !streaming_q;
    fsm_last_o = cnt == last_cnt || !(fsm_stream || mem_stream);
    fsm_data_o = mem_data_i;
    // N:1 swallows every mem beat but the last; 1:N holds its single mem beat until the last FSM beat
    fsm_v_o = mem_v_i && (!mem_only || fsm_last_o);
    mem_ready_and_o = (mem_only && !fsm_last_o) || (fsm_only ? fsm_ready_and_i && fsm_last_o : fsm_ready_and_i);
    fsm_addr_o = addr;
    fsm_addr_o[stream_offset_width_lp+:data_len_width_lp] = mem_only ? first_cnt
                                                          : (first_cnt & ~num_stream) | (cnt & num_stream);
    stream_done_o = fsm_v_o && fsm_ready_and_i && fsm_last_o;
    advance = fsm_only ? fsm_v_o && fsm_ready_and_i : mem_v_i && mem_ready_and_o;
    mem_last_beat = !mem_stream || fsm_last_o;
    streaming_d = !stream_done_o && (streaming_q || advance);
    cnt_d = (stream_done_o || single_lp) ? '0 : advance ? cnt + 1'b1 : cnt_q;
    header_d = (advance && !streaming_q) ? mem_header_i : header_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      streaming_q <= 1'b0;
      cnt_q <= '0;
      header_q <= '0;
    end else begin
      streaming_q <= streaming_d;
      cnt_q <= cnt_d;
      header_q <= header_d;
    end
  end
  assert property (@(posedge clk_i) disable iff (reset_i) (mem_v_i && mem_ready_and_o) |-> (mem_last_i == mem_last_beat));
endmodule

// File: tb/tb_bp_me_stream_pump_in.sv
// tb_bp_me_stream_pump_in: directed and random messages checked against a beat-index reference model.
module tb_bp_me_stream_pump_in;
  localparam int PA = 40;
  localparam int DW = 64;
  localparam int HW = PA + 7;
  localparam logic [15:0] FSM_MASK = 16'h0003;
  localparam logic [15:0] MEM_MASK = 16'h0006;
  logic clk = 1'b0;
  logic reset_i;
  logic [HW-1:0] mem_header_i, fsm_base_header_o;
  logic [DW-1:0] mem_data_i, fsm_data_o;
  logic mem_v_i, mem_last_i, mem_ready_and_o, fsm_v_o, fsm_ready_and_i, fsm_new_o, fsm_last_o, stream_done_o;
  logic [PA-1:0] fsm_addr_o;
  logic [2:0] fsm_cnt_o;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  bp_me_stream_pump_in #(
    .paddr_width_p(PA), .stream_data_width_p(DW), .block_width_p(512),
    .mem_stream_mask_p(MEM_MASK), .fsm_stream_mask_p(FSM_MASK)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .mem_header_i(mem_header_i), .mem_data_i(mem_data_i),
    .mem_v_i(mem_v_i), .mem_last_i(mem_last_i), .mem_ready_and_o(mem_ready_and_o),
    .fsm_base_header_o(fsm_base_header_o), .fsm_addr_o(fsm_addr_o), .fsm_data_o(fsm_data_o),
    .fsm_v_o(fsm_v_o), .fsm_ready_and_i(fsm_ready_and_i), .fsm_cnt_o(fsm_cnt_o),
    .fsm_new_o(fsm_new_o), .fsm_last_o(fsm_last_o), .stream_done_o(stream_done_o)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Sends one message; abort_after > 0 stops once that many FSM beats have been taken.
  task automatic send(input int typ, input logic [PA-1:0] addr, input int size, input int vpct, input int rpct,
                      input int stall_beat, input int stall_len, input int abort_after);
    logic [HW-1:0] hdr;
    logic [DW-1:0] d [16];
    logic [PA-1:0] bytes, exp_addr;
    int nb, f, m, total, mi, fi, b, cyc, stalled;
    bit fs, ms, n1, one_n, v, r, ev, er, last;
    hdr = {4'(typ), 3'(size), addr};
    bytes = PA'(1) << size;
    nb = (1 << size) / 8;
    if (nb < 1) nb = 1;
    fs = FSM_MASK[typ] && nb > 1;
    ms = MEM_MASK[typ] && nb > 1;
    f = fs ? nb : 1;
    m = ms ? nb : 1;
    total = f > m ? f : m;
    n1 = ms && !fs;
    one_n = fs && !ms;
    for (int i = 0; i < m; i++) d[i] = {$urandom, $urandom};
    mi = 0; fi = 0; cyc = 0; stalled = 0;
    while (!(mi == m && fi == f)) begin
      @(negedge clk);
      if (cyc++ > 300) begin
        checks++; errors++;
        $error("FAIL timeout message type=%0d addr=%0h mem_beats=%0d fsm_beats=%0d", typ, addr, mi, fi);
        break;
      end
      v = $urandom_range(99) < vpct;
      if (fi == stall_beat && stalled < stall_len) begin r = 0; stalled++; end
      else r = $urandom_range(99) < rpct;
      mem_v_i = v; mem_header_i = hdr; mem_data_i = d[mi]; mem_last_i = (mi == m - 1); fsm_ready_and_i = r;
      #2;
      b = one_n ? fi : mi;
      last = b == total - 1;
      ev = v && (!n1 || last);
      er = (n1 && !last) ? 1'b1 : one_n ? (r && last) : r;
      exp_addr = (nb == 1 || n1) ? addr : (addr & ~(bytes - 1)) | ((addr + PA'(8 * b)) & (bytes - 1));
      chk("fsm_v", fsm_v_o, ev);
      chk("done", stream_done_o, ev && r && last);
      chk("mem_ready", mem_ready_and_o, er);
      if (ev) begin
        chk("addr", fsm_addr_o, exp_addr);
        chk("cnt", fsm_cnt_o, 3'((addr >> 3) + PA'(b)));
        chk("data", fsm_data_o, d[mi]);
        chk("last", fsm_last_o, last);
        chk("new", fsm_new_o, b == 0);
        chk("header", fsm_base_header_o, hdr);
      end
      if (v && er) mi++;
      if (ev && r) fi++;
      if (abort_after > 0 && fi == abort_after) break;
    end
  endtask
  initial begin
    reset_i = 1'b1; mem_v_i = 1'b0; mem_last_i = 1'b0; mem_header_i = '0; mem_data_i = '0; fsm_ready_and_i = 1'b1;
    @(negedge clk);
    #2;
    chk("reset fsm_v", fsm_v_o, 0);
    chk("reset done", stream_done_o, 0);
    chk("reset cnt", fsm_cnt_o, 0);
    chk("reset new", fsm_new_o, 1);
    @(negedge clk);
    reset_i = 1'b0;
    send(1, 40'h1008, 3, 100, 100, -1, 0, 0);
    send(1, 40'h2010, 6, 100, 100, -1, 0, 0);
    send(0, 40'h30, 5, 100, 100, -1, 0, 0);
    send(2, 40'h30, 5, 100, 100, -1, 0, 0);
    send(1, 40'h3000, 6, 100, 100, 2, 3, 0);
    send(0, 40'h58, 6, 100, 100, 5, 3, 0);
    send(3, 40'h4438, 6, 100, 100, -1, 0, 0);
    send(1, 40'h2010, 6, 100, 100, -1, 0, 4);
    @(negedge clk);
    mem_v_i = 1'b0;
    #1;
    chk("mid-stream new", fsm_new_o, 0);
    reset_i = 1'b1;
    #1;
    chk("async reset new", fsm_new_o, 1);
    chk("async reset cnt", fsm_cnt_o, 3'd2);
    chk("async reset fsm_v", fsm_v_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    send(1, 40'h40, 6, 100, 100, -1, 0, 0);
    for (int k = 0; k < 40; k++)
      send($urandom_range(3), PA'({$urandom, $urandom}), $urandom_range(6), $urandom_range(100, 50), $urandom_range(100, 40), -1, 0, 0);
    @(negedge clk);
    mem_v_i = 1'b0;
    #2;
    chk("idle fsm_v", fsm_v_o, 0);
    chk("idle done", stream_done_o, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
